// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time instruction
// memory loader.
//   state_t         loader FSM states
//   HDR_BYTES       length-header size in bytes (little-endian word count)
//   BYTES_PER_WORD  payload bytes packed into one instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_byte(state_t s);
    return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: little-endian byte-to-word assembler with running XOR checksum.
//   clk_i, rst_n_i  clock / async active-low reset
//   clear_i         drop lane state and checksum (start of a session)
//   accept_i        byte_i is a payload byte this cycle
//   byte_i          payload byte
//   word_o          assembled word, valid while word_full_o is high
//   word_full_o     combinational pulse: this accept completes a word
//   csum_o          XOR of every payload byte accepted since clear
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o,
  output logic [7:0]  csum_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  // Only lanes 0..2 are stored; the top lane is the byte arriving on the
  // completing accept, so the word is ready in the same cycle.
  logic [2:0][7:0] lane_q;
  logic [1:0]      idx_q;
  logic [7:0]      csum_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lane_q <= '0;
      idx_q  <= '0;
      csum_q <= '0;
    end else if (clear_i) begin
      lane_q <= '0;
      idx_q  <= '0;
      csum_q <= '0;
    end else if (accept_i) begin
      case (idx_q)
        2'd0:    lane_q[0] <= byte_i;
        2'd1:    lane_q[1] <= byte_i;
        2'd2:    lane_q[2] <= byte_i;
        default: ;
      endcase
      idx_q  <= idx_q + 2'd1;
      csum_q <= csum_q ^ byte_i;
    end
  end

  assign word_o      = {byte_i, lane_q[2], lane_q[1], lane_q[0]};
  assign word_full_o = accept_i && (idx_q == LAST_LANE);
  assign csum_o      = csum_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader in front of the instruction memory. Receives a
// byte stream (word count N, 4*N little-endian payload bytes, XOR checksum),
// writes words from address 0 and holds the core in reset until the image
// is complete and verified.
//   clk_i, rst_n_i          clock / async active-low reset
//   start_i                 one-cycle pulse, begins a session (IDLE/DONE/ERR)
//   byte_valid_i/_data_i    stream input; byte_ready_o is the handshake
//   imem_we_o/addr_o/wd_o   registered instruction memory write port
//   cpu_reset_o             active-high core hold, low only in DONE
//   done_o, err_o           session result levels
//   word_count_o            words written in the current session
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wd_o,
  output logic          cpu_reset_o,
  output logic          done_o,
  output logic          err_o,
  output logic [15:0]   word_count_o
);

  state_t        state_q, state_d;
  logic [7:0]    nlo_q, nlo_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   wc_q, wc_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;

  logic          accept;
  logic          clear;
  logic [15:0]   n_hdr;
  logic [31:0]   pk_word;
  logic          pk_full;
  logic [7:0]    pk_csum;

  assign byte_ready_o = accepts_byte(state_q);
  assign accept       = byte_valid_i && byte_ready_o;
  assign n_hdr        = {byte_data_i, nlo_q};

  word_packer u_packer (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clear_i     (clear),
    .accept_i    (accept && (state_q == DATA)),
    .byte_i      (byte_data_i),
    .word_o      (pk_word),
    .word_full_o (pk_full),
    .csum_o      (pk_csum)
  );

  always_comb begin
    state_d = state_q;
    nlo_d   = nlo_q;
    n_d     = n_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = LEN0;
          wc_d    = '0;
          clear   = 1'b1;
        end
      end
      LEN0: begin
        if (accept) begin
          nlo_d   = byte_data_i;
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          n_d = n_hdr;
          // Oversized images are rejected here, so addresses never wrap.
          if (n_hdr == 16'd0 || n_hdr > 16'(DEPTH)) state_d = ERR;
          else                                      state_d = DATA;
        end
      end
      DATA: begin
        if (pk_full) begin
          we_d   = 1'b1;
          addr_d = wc_q[AW-1:0];
          wd_d   = pk_word;
          wc_d   = wc_q + 16'd1;
          if (wc_q + 16'd1 == n_q) state_d = CSUM;
        end
      end
      CSUM: begin
        if (accept) state_d = (byte_data_i == pk_csum) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      nlo_q   <= '0;
      n_q     <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      nlo_q   <= nlo_d;
      n_q     <= n_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wd_o    = wd_q;
  assign cpu_reset_o  = (state_q != DONE);
  assign done_o       = (state_q == DONE);
  assign err_o        = (state_q == ERR);
  assign word_count_o = wc_q;

endmodule
